// File: rtl/sgdmac_arb_pkg.sv
// Shared types and helpers for the SGDMAC burst arbiter.
// Latency: n/a (types and a combinational helper only).
// Backpressure: n/a.
// Contents: arb_state_t FSM encoding, rr_pick rotated first-one search.
package sgdmac_arb_pkg;

   typedef enum logic {ARB_IDLE = 1'b0, ARB_LOCKED = 1'b1} arb_state_t;

   // Widest request vector rr_pick can search.
   localparam int RR_MAX = 32;

   // Returns the first set bit of valid[n-1:0], searching ptr+1, ptr+2, ...
   // modulo n. Returns 0 when nothing is set; the caller qualifies with |valid.
   // The loop runs to a constant bound so it unrolls cleanly.
   function automatic int rr_pick(input logic [RR_MAX-1:0] valid,
                                  input int ptr,
                                  input int n);
      int   pick;
      int   idx;
      logic found;
      pick  = 0;
      found = 1'b0;
      for (int i = 1; i <= RR_MAX; i++) begin
         if (i <= n) begin
            // ptr < n and i <= n, so one conditional subtract wraps the index.
            idx = ptr + i;
            if (idx >= n) idx = idx - n;
            if (!found && valid[idx]) begin
               pick  = idx;
               found = 1'b1;
            end
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/sgdmac_skid_buffer.sv
// Two-entry skid buffer; registers the path and sustains one beat per cycle.
// Latency: a beat pushed in cycle t is presented on out_* in cycle t+1.
// Backpressure: in_ready is registered (low only when both entries are full).
// Ports: clk, rst (sync, active high); in_valid/in_ready/in_data push side;
//        out_valid/out_ready/out_data pop side, out_data always from entry 0.
module sgdmac_skid_buffer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);

   logic             v0;
   logic             v1;
   logic [WIDTH-1:0] d0;
   logic [WIDTH-1:0] d1;
   logic             push;
   logic             pop;

   // Entry 1 only fills while entry 0 is stalled, so space exists iff v1 is clear.
   assign in_ready  = ~v1;
   assign out_valid = v0;
   assign out_data  = d0;
   assign push      = in_valid & ~v1;
   assign pop       = v0 & out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         v0 <= 1'b0;
         v1 <= 1'b0;
      end else if (push) begin
         // push implies v1 == 0
         if (v0 && !pop) v1 <= 1'b1;
         v0 <= 1'b1;
      end else if (pop) begin
         if (v1) v1 <= 1'b0;
         else    v0 <= 1'b0;
      end
   end

   // Payload registers carry no reset; validity is tracked by v0/v1 alone.
   always_ff @(posedge clk) begin
      if (push) begin
         if (!v0 || pop) d0 <= in_data;
         else            d1 <= in_data;
      end else if (pop && v1) begin
         d0 <= d1;
      end
   end

endmodule

// File: rtl/sgdmac_burst_arbiter.sv
// N-way round-robin arbiter sharing one SGDMAC datapath port, locked per burst.
// Latency: an accepted beat appears on dst_* one cycle later at the earliest.
// Backpressure: req_ready_o drops for all requesters once the skid buffer is full.
// Ports: clk, rst (sync, active high); req_valid_i/req_ready_o/req_data_i/req_last_i
//        per requester; dst_valid_o/dst_ready_i/dst_data_o/dst_last_o/dst_src_o shared
//        output; busy_o (locked or buffered data); burst_err_o (forced-end pulse).
module sgdmac_burst_arbiter
   import sgdmac_arb_pkg::*;
#(
   parameter  int N_REQ     = 4,
   parameter  int DATA_SIZE = 32,
   parameter  int MAX_BEATS = 16,
   localparam int IDX_W     = $clog2(N_REQ)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [N_REQ-1:0]           req_valid_i,
   output logic [N_REQ-1:0]           req_ready_o,
   input  logic [N_REQ*DATA_SIZE-1:0] req_data_i,
   input  logic [N_REQ-1:0]           req_last_i,
   output logic                       dst_valid_o,
   input  logic                       dst_ready_i,
   output logic [DATA_SIZE-1:0]       dst_data_o,
   output logic                       dst_last_o,
   output logic [IDX_W-1:0]           dst_src_o,
   output logic                       busy_o,
   output logic                       burst_err_o
);

   localparam int CNT_W  = $clog2(MAX_BEATS + 1);
   localparam int SKID_W = DATA_SIZE + 1 + IDX_W;

   arb_state_t           state;
   arb_state_t           state_nxt;
   logic [IDX_W-1:0]     rr_ptr;
   logic [IDX_W-1:0]     lock_idx;
   logic [IDX_W-1:0]     gnt_idx;
   logic                 gnt_ok;
   logic [CNT_W-1:0]     beat_cnt;
   logic [CNT_W-1:0]     cnt_nxt;
   logic                 skid_in_ready;
   logic                 in_space;
   logic                 acc;
   logic                 acc_last;
   logic                 at_max;
   logic                 burst_end;
   logic                 forced;
   logic [DATA_SIZE-1:0] gnt_data;
   logic [SKID_W-1:0]    skid_in;
   logic [SKID_W-1:0]    skid_out;

   // Grant selection: rotating search while idle, pinned to the owner while locked
   // (even when the owner drops valid between beats).
   always_comb begin
      gnt_idx = lock_idx;
      gnt_ok  = 1'b1;
      if (state == ARB_IDLE) begin
         gnt_idx = IDX_W'(rr_pick(RR_MAX'(req_valid_i), int'(rr_ptr), N_REQ));
         gnt_ok  = |req_valid_i;
      end
   end

   // Nothing is accepted while reset is asserted, so no stray error pulse.
   assign in_space  = skid_in_ready & ~rst;
   assign acc       = |(req_valid_i & req_ready_o);
   assign acc_last  = req_last_i[gnt_idx];
   assign gnt_data  = req_data_i[int'(gnt_idx)*DATA_SIZE +: DATA_SIZE];
   assign cnt_nxt   = beat_cnt + CNT_W'(1);
   assign at_max    = (cnt_nxt == CNT_W'(MAX_BEATS));
   assign burst_end = acc & (acc_last | at_max);
   assign forced    = acc & at_max & ~acc_last;

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) state <= ARB_IDLE;
      else     state <= state_nxt;
   end

   // FSM next state
   always_comb begin
      state_nxt = state;
      case (state)
         ARB_IDLE:   if (acc && !burst_end) state_nxt = ARB_LOCKED;
         ARB_LOCKED: if (burst_end)         state_nxt = ARB_IDLE;
         default:    state_nxt = ARB_IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      req_ready_o = '0;
      if (gnt_ok && in_space) req_ready_o[gnt_idx] = 1'b1;
      burst_err_o = forced;
   end

   // Round-robin pointer, lock owner and beat counter. While locked gnt_idx
   // equals lock_idx, so loading rr_ptr from gnt_idx covers both burst ends.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr   <= IDX_W'(N_REQ - 1);
         lock_idx <= '0;
         beat_cnt <= '0;
      end else if (acc) begin
         if (burst_end) begin
            beat_cnt <= '0;
            rr_ptr   <= gnt_idx;
         end else begin
            beat_cnt <= cnt_nxt;
            if (state == ARB_IDLE) lock_idx <= gnt_idx;
         end
      end
   end

   // A forced end is marked as last so downstream sees a closed burst.
   assign skid_in = {gnt_idx, acc_last | at_max, gnt_data};

   sgdmac_skid_buffer #(
      .WIDTH(SKID_W)
   ) u_skid (
      .clk      (clk),
      .rst      (rst),
      .in_valid (acc),
      .in_ready (skid_in_ready),
      .in_data  (skid_in),
      .out_valid(dst_valid_o),
      .out_ready(dst_ready_i),
      .out_data (skid_out)
   );

   assign {dst_src_o, dst_last_o, dst_data_o} = skid_out;
   assign busy_o = (state == ARB_LOCKED) | dst_valid_o;

endmodule

// File: tb/tb_sgdmac_burst_arbiter.sv
// Directed bench for sgdmac_burst_arbiter (N_REQ=4, DATA_SIZE=32, MAX_BEATS=16).
// Latency: n/a.
// Backpressure: requester queues hold each beat until it is accepted.
module tb_sgdmac_burst_arbiter;

   localparam int N  = 4;
   localparam int DW = 32;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req_valid_i = '0;
   logic [N-1:0]    req_ready_o;
   logic [N*DW-1:0] req_data_i = '0;
   logic [N-1:0]    req_last_i = '0;
   logic            dst_valid_o;
   logic            dst_ready_i;
   logic [DW-1:0]   dst_data_o;
   logic            dst_last_o;
   logic [1:0]      dst_src_o;
   logic            busy_o;
   logic            burst_err_o;

   sgdmac_burst_arbiter #(.N_REQ(N), .DATA_SIZE(DW), .MAX_BEATS(16)) dut (
      .clk(clk), .rst(rst),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_data_i(req_data_i), .req_last_i(req_last_i),
      .dst_valid_o(dst_valid_o), .dst_ready_i(dst_ready_i),
      .dst_data_o(dst_data_o), .dst_last_o(dst_last_o), .dst_src_o(dst_src_o),
      .busy_o(busy_o), .burst_err_o(burst_err_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      int src;
      int data;
      bit last;
      int cyc;
   } beat_t;

   beat_t        out_q[$];
   beat_t        acc_q[$];
   int           err_q[$];
   logic [DW:0]  rq[N][$];          // {last, data} per requester
   logic [N-1:0] hold     = '0;
   logic [N-1:0] acc_prev = '0;
   int           cyc      = 0;
   int           n_pass   = 0;
   int           n_total  = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Log handshakes mid-cycle, where all inputs and outputs are settled.
   always @(negedge clk) begin
      beat_t b;
      acc_prev = req_valid_i & req_ready_o;
      for (int k = 0; k < N; k++) begin
         if (acc_prev[k]) begin
            b.src = k; b.data = int'(req_data_i[k*DW +: DW]);
            b.last = req_last_i[k]; b.cyc = cyc;
            acc_q.push_back(b);
         end
      end
      if (dst_valid_o && dst_ready_i) begin
         b.src = int'(dst_src_o); b.data = int'(dst_data_o);
         b.last = dst_last_o; b.cyc = cyc;
         out_q.push_back(b);
      end
      if (burst_err_o) err_q.push_back(cyc);
   end

   // Requester model: present queue head, retire it once accepted.
   initial begin
      logic [DW:0] e;
      forever begin
         @(posedge clk);
         #1;
         for (int k = 0; k < N; k++) begin
            if (acc_prev[k] && rq[k].size() > 0) rq[k].delete(0);
            if (rq[k].size() > 0 && !hold[k]) begin
               e = rq[k][0];
               req_valid_i[k] = 1'b1;
               req_last_i[k]  = e[DW];
               req_data_i[k*DW +: DW] = e[DW-1:0];
            end else begin
               req_valid_i[k] = 1'b0;
               req_last_i[k]  = 1'b0;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic clear_logs();
      out_q.delete();
      acc_q.delete();
      err_q.delete();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      dst_ready_i = 1'b1;
      repeat (3) tick();
      n_total++; if (dst_valid_o !== 1'b0) $display("FAIL reset_dst_valid got %b want 0", dst_valid_o); else n_pass++;
      n_total++; if (req_ready_o !== 4'b0) $display("FAIL reset_req_ready got %b want 0000", req_ready_o); else n_pass++;
      n_total++; if (busy_o !== 1'b0) $display("FAIL reset_busy got %b want 0", busy_o); else n_pass++;
      n_total++; if (burst_err_o !== 1'b0) $display("FAIL reset_burst_err got %b want 0", burst_err_o); else n_pass++;
      rst = 1'b0;
      tick();
      tick();
      n_total++; if (req_ready_o !== 4'b0) $display("FAIL idle_req_ready got %b want 0000", req_ready_o); else n_pass++;
      n_total++; if (dst_valid_o !== 1'b0 || busy_o !== 1'b0) $display("FAIL idle_outputs got valid=%b busy=%b want 0 0", dst_valid_o, busy_o); else n_pass++;
   endtask

   task automatic test_fairness();
      clear_logs();
      for (int r = 0; r < 2; r++)
         for (int k = 0; k < N; k++) rq[k].push_back({1'b1, DW'(32'hA0 + k)});
      for (int i = 0; i < 100 && out_q.size() < 8; i++) tick();
      n_total++; if (out_q.size() != 8) $display("FAIL fair_count got %0d want 8", out_q.size()); else n_pass++;
      for (int i = 0; i < out_q.size() && i < 8; i++) begin
         n_total++;
         if (out_q[i].src != i % 4 || out_q[i].data != 32'hA0 + i % 4 || !out_q[i].last)
            $display("FAIL fair_beat[%0d] got src=%0d data=%h last=%b want src=%0d data=%h last=1",
                     i, out_q[i].src, out_q[i].data, out_q[i].last, i % 4, 32'hA0 + i % 4);
         else n_pass++;
         n_total++;
         if (out_q[i].cyc != out_q[0].cyc + i)
            $display("FAIL fair_rate[%0d] got cycle %0d want %0d", i, out_q[i].cyc, out_q[0].cyc + i);
         else n_pass++;
      end
      n_total++;
      if (out_q.size() == 0 || acc_q.size() == 0 || out_q[0].cyc != acc_q[0].cyc + 1)
         $display("FAIL fair_latency got out/acc logs %0d/%0d want first beat 1 cycle after accept",
                  out_q.size(), acc_q.size());
      else n_pass++;
   endtask

   task automatic test_lock();
      int es[5] = '{1, 1, 1, 1, 2};
      int ed[5] = '{'h10, 'h11, 'h12, 'h13, 'h20};
      bit el[5] = '{0, 0, 0, 1, 1};
      clear_logs();
      for (int i = 0; i < 4; i++) rq[1].push_back({1'(i == 3), DW'(32'h10 + i)});
      rq[2].push_back({1'b1, DW'(32'h20)});
      for (int i = 0; i < 100 && out_q.size() < 5; i++) tick();
      n_total++; if (out_q.size() != 5) $display("FAIL lock_count got %0d want 5", out_q.size()); else n_pass++;
      for (int i = 0; i < out_q.size() && i < 5; i++) begin
         n_total++;
         if (out_q[i].src != es[i] || out_q[i].data != ed[i] || out_q[i].last != el[i])
            $display("FAIL lock_beat[%0d] got src=%0d data=%h last=%b want src=%0d data=%h last=%b",
                     i, out_q[i].src, out_q[i].data, out_q[i].last, es[i], ed[i], el[i]);
         else n_pass++;
      end
      for (int i = 0; i < acc_q.size() && i < 5; i++) begin
         n_total++;
         if (acc_q[i].src != es[i]) $display("FAIL lock_grant[%0d] got %0d want %0d", i, acc_q[i].src, es[i]);
         else n_pass++;
      end
   endtask

   task automatic test_backpressure();
      clear_logs();
      dst_ready_i = 1'b0;
      for (int i = 0; i < 6; i++) rq[0].push_back({1'(i == 5), DW'(32'h30 + i)});
      repeat (3) tick();
      for (int j = 0; j < 3; j++) begin
         n_total++;
         if (req_ready_o[0] !== 1'b0 || req_valid_i[0] !== 1'b1)
            $display("FAIL bp_ready[%0d] got ready=%b valid=%b want 0 1", j, req_ready_o[0], req_valid_i[0]);
         else n_pass++;
         n_total++;
         if (dst_valid_o !== 1'b1 || dst_data_o !== 32'h30)
            $display("FAIL bp_hold[%0d] got valid=%b data=%h want 1 00000030", j, dst_valid_o, dst_data_o);
         else n_pass++;
         n_total++;
         if (acc_q.size() != 2) $display("FAIL bp_buffered[%0d] got %0d want 2", j, acc_q.size());
         else n_pass++;
         tick();
      end
      dst_ready_i = 1'b1;
      for (int i = 0; i < 100 && out_q.size() < 6; i++) tick();
      n_total++; if (out_q.size() != 6) $display("FAIL bp_count got %0d want 6", out_q.size()); else n_pass++;
      for (int i = 0; i < out_q.size() && i < 6; i++) begin
         n_total++;
         if (out_q[i].src != 0 || out_q[i].data != 32'h30 + i || out_q[i].last != (i == 5))
            $display("FAIL bp_beat[%0d] got src=%0d data=%h last=%b want src=0 data=%h last=%b",
                     i, out_q[i].src, out_q[i].data, out_q[i].last, 32'h30 + i, i == 5);
         else n_pass++;
      end
   endtask

   task automatic test_forced_end();
      int es[$];
      int ed[$];
      bit el[$];
      clear_logs();
      // 20 beats without last; the final one closes the trailing burst.
      for (int i = 0; i < 20; i++) rq[3].push_back({1'(i == 19), DW'(32'h40 + i)});
      for (int i = 0; i < 16; i++) begin es.push_back(3); ed.push_back(32'h40 + i); el.push_back(i == 15); end
      es.push_back(1); ed.push_back(32'h60); el.push_back(1'b1);
      for (int i = 16; i < 20; i++) begin es.push_back(3); ed.push_back(32'h40 + i); el.push_back(i == 19); end
      repeat (3) tick();
      rq[1].push_back({1'b1, DW'(32'h60)});
      for (int i = 0; i < 150 && out_q.size() < 21; i++) tick();
      n_total++; if (out_q.size() != 21) $display("FAIL forced_count got %0d want 21", out_q.size()); else n_pass++;
      for (int i = 0; i < out_q.size() && i < 21; i++) begin
         n_total++;
         if (out_q[i].src != es[i] || out_q[i].data != ed[i] || out_q[i].last != el[i])
            $display("FAIL forced_beat[%0d] got src=%0d data=%h last=%b want src=%0d data=%h last=%b",
                     i, out_q[i].src, out_q[i].data, out_q[i].last, es[i], ed[i], el[i]);
         else n_pass++;
      end
      n_total++; if (err_q.size() != 1) $display("FAIL forced_err_pulses got %0d want 1", err_q.size()); else n_pass++;
      n_total++;
      if (err_q.size() < 1 || acc_q.size() < 16 || err_q[0] != acc_q[15].cyc)
         $display("FAIL forced_err_cycle got pulses=%0d accepts=%0d want pulse on 16th accept",
                  err_q.size(), acc_q.size());
      else n_pass++;
   endtask

   task automatic test_gap_in_lock();
      clear_logs();
      for (int i = 0; i < 5; i++) rq[0].push_back({1'(i == 4), DW'(32'h70 + i)});
      rq[1].push_back({1'b1, DW'(32'h80)});
      tick();
      tick();
      hold[0] = 1'b1;
      for (int j = 0; j < 3; j++) begin
         tick();
         n_total++;
         if (req_ready_o[1] !== 1'b0 || req_valid_i[1] !== 1'b1 || req_valid_i[0] !== 1'b0)
            $display("FAIL gap_no_grant[%0d] got ready1=%b valid1=%b valid0=%b want 0 1 0",
                     j, req_ready_o[1], req_valid_i[1], req_valid_i[0]);
         else n_pass++;
      end
      hold[0] = 1'b0;
      for (int i = 0; i < 100 && out_q.size() < 6; i++) tick();
      n_total++; if (out_q.size() != 6) $display("FAIL gap_count got %0d want 6", out_q.size()); else n_pass++;
      for (int i = 0; i < out_q.size() && i < 6; i++) begin
         n_total++;
         if (out_q[i].src != (i == 5 ? 1 : 0) || out_q[i].data != (i == 5 ? 32'h80 : 32'h70 + i))
            $display("FAIL gap_beat[%0d] got src=%0d data=%h want src=%0d data=%h",
                     i, out_q[i].src, out_q[i].data, i == 5 ? 1 : 0, i == 5 ? 32'h80 : 32'h70 + i);
         else n_pass++;
      end
      n_total++;
      if (acc_q.size() < 3 || acc_q[2].cyc - acc_q[1].cyc != 4)
         $display("FAIL gap_length got accepts=%0d want 4-cycle spacing between beats 2 and 3", acc_q.size());
      else n_pass++;
   endtask

   task automatic test_reset_mid_burst();
      clear_logs();
      dst_ready_i = 1'b0;
      rq[2].push_back({1'b0, DW'(32'h91)});
      rq[2].push_back({1'b0, DW'(32'h92)});
      rq[2].push_back({1'b1, DW'(32'h93)});
      repeat (3) tick();
      n_total++;
      if (dst_valid_o !== 1'b1 || busy_o !== 1'b1 || req_ready_o !== 4'b0)
         $display("FAIL rstmid_full got valid=%b busy=%b ready=%b want 1 1 0000", dst_valid_o, busy_o, req_ready_o);
      else n_pass++;
      rst = 1'b1;
      for (int k = 0; k < N; k++) rq[k].delete();
      tick();
      n_total++; if (dst_valid_o !== 1'b0) $display("FAIL rstmid_dst_valid got %b want 0", dst_valid_o); else n_pass++;
      n_total++; if (busy_o !== 1'b0) $display("FAIL rstmid_busy got %b want 0", busy_o); else n_pass++;
      rst = 1'b0;
      dst_ready_i = 1'b1;
      clear_logs();
      for (int k = 0; k < N; k++) rq[k].push_back({1'b1, DW'(32'hB0 + k)});
      for (int i = 0; i < 100 && out_q.size() < 4; i++) tick();
      repeat (3) tick();
      n_total++; if (out_q.size() != 4) $display("FAIL rstmid_count got %0d want 4", out_q.size()); else n_pass++;
      n_total++;
      if (acc_q.size() < 1 || acc_q[0].src != 0)
         $display("FAIL rstmid_first_grant got accepts=%0d want first grant to requester 0", acc_q.size());
      else n_pass++;
      for (int i = 0; i < out_q.size() && i < 4; i++) begin
         n_total++;
         if (out_q[i].src != i || out_q[i].data != 32'hB0 + i)
            $display("FAIL rstmid_beat[%0d] got src=%0d data=%h want src=%0d data=%h",
                     i, out_q[i].src, out_q[i].data, i, 32'hB0 + i);
         else n_pass++;
      end
   endtask

   initial begin
      rst = 1'b1;
      dst_ready_i = 1'b1;
      test_reset();
      test_fairness();
      test_lock();
      test_backpressure();
      test_forced_end();
      test_gap_in_lock();
      test_reset_mid_burst();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
